hard_limiter: RTL and testbench



---
 rtl/hard_limiter_pkg.sv | 28 ++
 rtl/hard_limiter_limits_fifo.sv | 97 +++++++++
 rtl/hard_limiter.sv | 215 +++++++++++++++++++++
 tb/tb_hard_limiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hard_limiter_pkg.sv
// -----------------------------------------------------------------------------
// hard_limiter_pkg
// Shared types and constants for the hard-limiter stage of the reconstruction
// loop.
//   DEFAULT_DATA_W : default sample width (signed two's complement)
//   IDX_W          : width of the per-iteration sample index
//   STAT_W         : width of the optional clip statistics counters
//   limits_t       : one limit word, {upper, lower}, as packed on limits_data
//   clip_t         : outcome of the clamp for one sample
// -----------------------------------------------------------------------------
package hard_limiter_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int IDX_W          = 8;
    localparam int STAT_W         = 16;

    typedef struct packed {
        logic signed [DEFAULT_DATA_W-1:0] upper;
        logic signed [DEFAULT_DATA_W-1:0] lower;
    } limits_t;

    typedef enum logic [1:0] {
        CLIP_NONE = 2'd0,
        CLIP_HI   = 2'd1,
        CLIP_LO   = 2'd2
    } clip_t;

endpackage

// File: rtl/hard_limiter_limits_fifo.sv
// -----------------------------------------------------------------------------
// hard_limiter_limits_fifo
// Synchronous FIFO holding limit words between the limits buffer and the clamp.
// A word written on one edge becomes visible on pop_data_o the cycle after
// (no write-to-read bypass). A push that meets a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is dropped and drop_o
// pulses for that cycle.
// Ports:
//   clock, reset  : clock, synchronous active-high reset (FIFO emptied)
//   push_i        : write request, push_data_i the word to write
//   pop_i         : read request (ignored while empty)
//   pop_data_o    : word at the head of the FIFO
//   empty_o       : no word available
//   drop_o        : push lost because the FIFO was full and not popped
// -----------------------------------------------------------------------------
module hard_limiter_limits_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Occupancy flags and accepted push/pop qualification.
    always_comb begin
        full_s    = (count_q == CW'(DEPTH));
        empty_s   = (count_q == {CW{1'b0}});
        pop_ok_s  = pop_i & ~empty_s;
        // A full FIFO still takes the word when the head leaves this cycle.
        push_ok_s = push_i & (~full_s | pop_ok_s);
    end

    // Pointer and occupancy next state; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are only meaningful while counted as occupied.
    always_ff @(posedge clock) begin
        if (push_ok_s && !reset) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = empty_s;
    assign drop_o     = push_i & full_s & ~pop_ok_s;

endmodule

// File: rtl/hard_limiter.sv
// -----------------------------------------------------------------------------
// hard_limiter
// Pairs each reconstructed sample with the next limit word {upper, lower} from
// the limits buffer and clamps it into [lower, upper] (signed). Results leave
// through a registered valid/ready output with an end-of-iteration marker.
// Optional build macro: HARD_LIMITER_STATS_EN adds saturating clip counters.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   limits_data/valid       : limit word {upper, lower}, no backpressure
//   sig_data/valid/ready    : sample input handshake
//   out_data/valid/ready    : clamped sample output handshake
//   out_last                : output is the last sample of an iteration
//   overflow                : sticky, a limit word was dropped on a full FIFO
//   limit_err               : sticky, a sample was paired with lower > upper
//   err_clear               : clears both sticky flags (wins over a set)
//   clip_hi_cnt/clip_lo_cnt : (stats build) saturating clip counts
//   stats_clear             : (stats build) zeroes both counters
// -----------------------------------------------------------------------------
module hard_limiter
    import hard_limiter_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_SAMPLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2*DATA_W-1:0] limits_data,
    input  logic                limits_valid,
    input  logic [DATA_W-1:0]   sig_data,
    input  logic                sig_valid,
    output logic                sig_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                overflow,
    output logic                limit_err,
`ifdef HARD_LIMITER_STATS_EN
    output logic [STAT_W-1:0]   clip_hi_cnt,
    output logic [STAT_W-1:0]   clip_lo_cnt,
    input  logic                stats_clear,
`endif
    input  logic                err_clear
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SAMPLES - 1);

    // Invalid pairs (lower > upper) resolve to lower, so they classify as low clips.
    function automatic clip_t classify(input logic signed [DATA_W-1:0] s,
                                       input logic signed [DATA_W-1:0] u,
                                       input logic signed [DATA_W-1:0] l);
        clip_t c;
        if (l > u) begin
            c = CLIP_LO;
        end else if (s > u) begin
            c = CLIP_HI;
        end else if (s < l) begin
            c = CLIP_LO;
        end else begin
            c = CLIP_NONE;
        end
        return c;
    endfunction

    logic [2*DATA_W-1:0]      lim_word_s;
    logic                     fifo_empty_s;
    logic                     fifo_drop_s;
    logic                     sig_ready_s;
    logic                     fire_s;
    logic signed [DATA_W-1:0] upper_s;
    logic signed [DATA_W-1:0] lower_s;
    logic signed [DATA_W-1:0] sample_s;
    logic                     pair_bad_s;
    clip_t                    clip_s;
    logic [DATA_W-1:0]        clamp_s;

    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic              overflow_q,  overflow_d;
    logic              limit_err_q, limit_err_d;

    hard_limiter_limits_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_limits_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (limits_valid),
        .push_data_i (limits_data),
        .pop_i       (fire_s),
        .pop_data_o  (lim_word_s),
        .empty_o     (fifo_empty_s),
        .drop_o      (fifo_drop_s)
    );

    // A sample is taken only when a limit word is waiting and the output slot frees up.
    assign sig_ready_s = ~fifo_empty_s & (~out_valid_q | out_ready);
    assign fire_s      = sig_valid & sig_ready_s;

    // Signed clamp of the incoming sample against the head limit word.
    always_comb begin
        upper_s    = $signed(lim_word_s[2*DATA_W-1:DATA_W]);
        lower_s    = $signed(lim_word_s[DATA_W-1:0]);
        sample_s   = $signed(sig_data);
        pair_bad_s = (lower_s > upper_s);
        clip_s     = classify(sample_s, upper_s, lower_s);
        case (clip_s)
            CLIP_HI: clamp_s = upper_s;
            CLIP_LO: clamp_s = lower_s;
            default: clamp_s = sample_s;
        endcase
    end

    // Output slot and iteration index next state.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        idx_d       = idx_q;
        if (fire_s) begin
            out_data_d  = clamp_s;
            out_valid_d = 1'b1;
            out_last_d  = (idx_q == LAST_IDX);
            if (idx_q == LAST_IDX) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (out_ready) begin
            // Handshake with nothing new behind it empties the slot.
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Sticky error flags; clearing wins over a same-cycle set.
    always_comb begin
        if (err_clear) begin
            overflow_d  = 1'b0;
            limit_err_d = 1'b0;
        end else begin
            overflow_d  = overflow_q | fifo_drop_s;
            limit_err_d = limit_err_q | (fire_s & pair_bad_s);
        end
    end

    // Output, iteration and sticky-flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            idx_q       <= {IDX_W{1'b0}};
            overflow_q  <= 1'b0;
            limit_err_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            idx_q       <= idx_d;
            overflow_q  <= overflow_d;
            limit_err_q <= limit_err_d;
        end
    end

    assign sig_ready = sig_ready_s;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign limit_err = limit_err_q;

`ifdef HARD_LIMITER_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [STAT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [STAT_W-1:0] lo_cnt_q, lo_cnt_d;

    // Saturating clip counters; a clear wins over a same-cycle increment.
    always_comb begin
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        if (stats_clear) begin
            hi_cnt_d = {STAT_W{1'b0}};
            lo_cnt_d = {STAT_W{1'b0}};
        end else if (fire_s && (clip_s == CLIP_HI) && (hi_cnt_q != STAT_MAX)) begin
            hi_cnt_d = hi_cnt_q + STAT_W'(1);
        end else if (fire_s && (clip_s == CLIP_LO) && (lo_cnt_q != STAT_MAX)) begin
            lo_cnt_d = lo_cnt_q + STAT_W'(1);
        end else begin
            hi_cnt_d = hi_cnt_q;
        end
    end

    // Clip counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_cnt_q <= {STAT_W{1'b0}};
            lo_cnt_q <= {STAT_W{1'b0}};
        end else begin
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
        end
    end

    assign clip_hi_cnt = hi_cnt_q;
    assign clip_lo_cnt = lo_cnt_q;
`endif

endmodule

// File: tb/tb_hard_limiter.sv
// -----------------------------------------------------------------------------
// tb_hard_limiter
// Self-checking bench for hard_limiter. A transaction-level reference model
// (queue of limit words, clamp by plain integer arithmetic, index modulo
// MAX_SAMPLES) predicts every output each cycle. Directed sequences cover the
// documented scenarios, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_hard_limiter;
    import hard_limiter_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int MAXS  = 255;
    localparam int SMAX  = 65535;

    logic            clock = 1'b0;
    logic            reset;
    logic [2*DW-1:0] limits_data;
    logic            limits_valid;
    logic [DW-1:0]   sig_data;
    logic            sig_valid;
    logic            sig_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            overflow;
    logic            limit_err;
    logic            err_clear;
`ifdef HARD_LIMITER_STATS_EN
    logic [15:0]     clip_hi_cnt;
    logic [15:0]     clip_lo_cnt;
    logic            stats_clear;
`endif

    always #5 clock = ~clock;

    hard_limiter #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .MAX_SAMPLES (MAXS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .limits_data  (limits_data),
        .limits_valid (limits_valid),
        .sig_data     (sig_data),
        .sig_valid    (sig_valid),
        .sig_ready    (sig_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .overflow     (overflow),
        .limit_err    (limit_err),
`ifdef HARD_LIMITER_STATS_EN
        .clip_hi_cnt  (clip_hi_cnt),
        .clip_lo_cnt  (clip_lo_cnt),
        .stats_clear  (stats_clear),
`endif
        .err_clear    (err_clear)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state.
    limits_t m_q[$];
    bit      m_valid, m_last, m_ovf, m_lerr;
    int      m_data, m_idx, m_hi, m_lo;

    task automatic check_val(input string tag, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_valid = 1'b0; m_last = 1'b0; m_ovf = 1'b0; m_lerr = 1'b0;
        m_data = 0; m_idx = 0; m_hi = 0; m_lo = 0;
    endtask

    // Advance the model by one clock edge given the inputs applied this cycle.
    task automatic model_step(input bit lv, input int up, input int lo, input bit sv,
                              input int sd, input bit ordy, input bit eclr,
                              input bit sclr, input bit rst);
        bit      rdy, fire, drop, bad, hi_clip, lo_clip;
        int      u, l;
        limits_t w;
        if (rst) begin
            model_reset();
            return;
        end
        rdy  = (m_q.size() > 0) && (!m_valid || ordy);
        fire = sv && rdy;
        drop = lv && (m_q.size() == DEPTH) && !fire;
        bad = 1'b0; hi_clip = 1'b0; lo_clip = 1'b0;
        if (fire) begin
            w = m_q.pop_front();
            u = w.upper;
            l = w.lower;
            if (l > u)       begin m_data = l; bad = 1'b1; lo_clip = 1'b1; end
            else if (sd > u) begin m_data = u; hi_clip = 1'b1; end
            else if (sd < l) begin m_data = l; lo_clip = 1'b1; end
            else             begin m_data = sd; end
            m_valid = 1'b1;
            m_last  = (m_idx == MAXS - 1);
            m_idx   = (m_idx + 1) % MAXS;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (lv && !drop) begin
            w.upper = up[15:0];
            w.lower = lo[15:0];
            m_q.push_back(w);
        end
        if (eclr) begin
            m_ovf = 1'b0; m_lerr = 1'b0;
        end else begin
            m_ovf  = m_ovf | drop;
            m_lerr = m_lerr | bad;
        end
        if (sclr) begin
            m_hi = 0; m_lo = 0;
        end else begin
            if (hi_clip && m_hi < SMAX) m_hi++;
            if (lo_clip && m_lo < SMAX) m_lo++;
        end
    endtask

    // Apply inputs for one cycle, check outputs mid-cycle, then step the model.
    task automatic drive(input bit lv, input int up, input int lo, input bit sv,
                         input int sd, input bit ordy, input bit eclr,
                         input bit sclr, input bit rst);
        bit exp_rdy;
        limits_valid = lv;
        limits_data  = {up[15:0], lo[15:0]};
        sig_valid    = sv;
        sig_data     = sd[15:0];
        out_ready    = ordy;
        err_clear    = eclr;
        reset        = rst;
`ifdef HARD_LIMITER_STATS_EN
        stats_clear  = sclr;
`endif
        @(negedge clock);
        exp_rdy = (m_q.size() > 0) && (!m_valid || ordy);
        check_val("sig_ready", sig_ready, exp_rdy);
        check_val("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check_val("out_data", $signed(out_data), m_data);
            check_val("out_last", out_last, m_last);
        end
        check_val("overflow", overflow, m_ovf);
        check_val("limit_err", limit_err, m_lerr);
`ifdef HARD_LIMITER_STATS_EN
        check_val("clip_hi_cnt", clip_hi_cnt, m_hi);
        check_val("clip_lo_cnt", clip_lo_cnt, m_lo);
`endif
        model_step(lv, up, lo, sv, sd, ordy, eclr, sclr, rst);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic int rnd_val();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 400)) - 200;
    endfunction

    initial begin
        int up, lo, t;
        reset = 1'b1; limits_valid = 1'b0; limits_data = '0; sig_valid = 1'b0;
        sig_data = '0; out_ready = 1'b1; err_clear = 1'b0;
`ifdef HARD_LIMITER_STATS_EN
        stats_clear = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        check_val("rst_out_data", $signed(out_data), 0);
        check_val("rst_out_last", out_last, 0);
        idle(1);

        // Basic clamp: {100,-100} with samples 50, 150, -200.
        drive(1'b1, 100, -100, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 100, -100, 1'b1, 50, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 100, -100, 1'b1, 150, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, -200, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Overflow: five pushes into a four-deep FIFO, drain in order, then clear.
        for (int k = 1; k <= 5; k++) drive(1'b1, 10 * k, -10 * k, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int k = 0; k < 4; k++) drive(1'b0, 0, 0, 1'b1, 1000, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Invalid pair lower=10 > upper=5 with sample 7.
        drive(1'b1, 5, 10, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Output stall for three cycles, then a single handshake.
        drive(1'b1, 100, -100, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 100, -100, 1'b1, 20, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 0, 0, 1'b1, 30, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, 500, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Reset with a held output and two FIFO entries.
        drive(1'b1, 50, -50, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 60, -60, 1'b1, 90, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 70, -70, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 40, -40, 1'b1, 45, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 1'b1, -45, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Back-to-back stream across an iteration boundary (256 fires).
        for (int i = 0; i < 257; i++) drive(1'b1, 300, -300, i > 0, rnd_val(), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            up = rnd_val();
            lo = rnd_val();
            if (lo > up && $urandom_range(0, 9) != 0) begin
                t = lo; lo = up; up = t;
            end
            drive($urandom_range(0, 9) < 6, up, lo, $urandom_range(0, 9) < 7, rnd_val(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
